// File: rtl/mlaccel_memarb.sv
// Arbiter for the single-port main memory: C > Q > S fixed priority with a
// starvation guard for Q/S, combinational grants and tagged read returns.
module mlaccel_memarb #(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic [1:0]  c_wen,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  input  logic        q_req,
  input  logic [1:0]  q_wen,
  input  logic [15:0] q_addr,
  input  logic [15:0] q_wdata,
  output logic        q_gnt,
  output logic        q_rvalid,
  input  logic        s_req,
  input  logic [15:0] s_addr,
  output logic        s_gnt,
  output logic        s_rvalid,
  output logic [15:0] mem_addr,
  output logic [1:0]  mem_wen,
  output logic [15:0] mem_wdata,
  input  logic [63:0] rdata_in,
  output logic [63:0] rdata,
  output logic        starve_q,
  output logic        starve_s
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_C    = 2'd1;
  localparam logic [1:0] TAG_Q    = 2'd2;
  localparam logic [1:0] TAG_S    = 2'd3;

  logic [CW-1:0] wait_q, wait_s;
  logic          force_q, force_s;
  logic [1:0]    push_tag;
  logic [1:0]    tag_pipe [RD_LAT];

  // A saturated counter only forces a grant while the request is still up;
  // a withdrawn request must not be granted.
  assign force_q = q_req && (wait_q == WAIT_MAX);
  assign force_s = s_req && (wait_s == WAIT_MAX);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    c_gnt    = 1'b0;
    q_gnt    = 1'b0;
    s_gnt    = 1'b0;
    starve_q = 1'b0;
    starve_s = 1'b0;
    if (!reset) begin
      if (force_q) begin
        q_gnt    = 1'b1;
        starve_q = 1'b1;
      end else if (force_s) begin
        s_gnt    = 1'b1;
        starve_s = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (q_req) begin
        q_gnt = 1'b1;
      end else if (s_req) begin
        s_gnt = 1'b1;
      end
    end
  end

  // Idle bus parks on c_addr with writes disabled.
  always_comb begin
    mem_addr  = c_addr;
    mem_wen   = 2'b00;
    mem_wdata = 16'h0000;
    push_tag  = TAG_NONE;
    if (c_gnt) begin
      mem_wen   = c_wen;
      mem_wdata = c_wdata;
      push_tag  = (c_wen == 2'b00) ? TAG_C : TAG_NONE;
    end else if (q_gnt) begin
      mem_addr  = q_addr;
      mem_wen   = q_wen;
      mem_wdata = q_wdata;
      push_tag  = (q_wen == 2'b00) ? TAG_Q : TAG_NONE;
    end else if (s_gnt) begin
      mem_addr  = s_addr;
      push_tag  = TAG_S;
    end
  end

  function automatic logic [CW-1:0] wait_next(input logic req, input logic gnt,
                                              input logic [CW-1:0] cnt);
    if (!req || gnt)      return '0;
    if (cnt == WAIT_MAX)  return cnt;
    return cnt + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    if (reset) begin
      wait_q <= '0;
      wait_s <= '0;
    end else begin
      wait_q <= wait_next(q_req, q_gnt, wait_q);
      wait_s <= wait_next(s_req, s_gnt, wait_s);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: the tag pipeline is a handful of flops, not a RAM, so it is reset;
    // this is what drops reads that were in flight when reset arrived.
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign c_rvalid = !reset && (tag_pipe[RD_LAT-1] == TAG_C);
  assign q_rvalid = !reset && (tag_pipe[RD_LAT-1] == TAG_Q);
  assign s_rvalid = !reset && (tag_pipe[RD_LAT-1] == TAG_S);

  assign rdata = rdata_in;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Directed bench for mlaccel_memarb with a small behavioural memory that has
// a two-cycle read latency behind the arbiter.
module tb_mlaccel_memarb;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_req, q_req, s_req;
  logic [1:0]  c_wen, q_wen;
  logic [15:0] c_addr, c_wdata, q_addr, q_wdata, s_addr;
  logic        c_gnt, q_gnt, s_gnt, c_rvalid, q_rvalid, s_rvalid;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  mem_wen;
  logic [63:0] rdata_in, rdata;
  logic        starve_q, starve_s;
  logic        preload;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mlaccel_memarb #(.RD_LAT(2), .MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .q_req(q_req), .q_wen(q_wen), .q_addr(q_addr), .q_wdata(q_wdata),
    .q_gnt(q_gnt), .q_rvalid(q_rvalid),
    .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .rdata_in(rdata_in), .rdata(rdata),
    .starve_q(starve_q), .starve_s(starve_s)
  );

  // Memory model: 256 words, initial contents derived from the address.
  logic [63:0] mem [256];
  logic [63:0] rd_pipe [2];

  function automatic logic [63:0] init_word(input logic [7:0] a);
    return {16'hCAFE, 8'h00, a, 16'h1234, 8'h00, a};
  endfunction

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
    end else begin
      if (mem_wen[0]) mem[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
      if (mem_wen[1]) mem[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
    end
    rd_pipe[0] <= mem[mem_addr[7:0]];
    rd_pipe[1] <= rd_pipe[0];
  end

  assign rdata_in = rd_pipe[1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_onehot(input string tag);
    check(tag, 64'($countones({c_gnt, q_gnt, s_gnt}) > 1), 64'd0);
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    c_req = 0; q_req = 0; s_req = 0;
    c_wen = 0; q_wen = 0; c_addr = 0; q_addr = 0; s_addr = 0;
    c_wdata = 0; q_wdata = 0;
    tick(); tick();

    // Requests are ignored while reset is high
    c_req = 1; c_wen = 2'b11; c_wdata = 16'h5555; q_req = 1;
    #1;
    check("rst_c_gnt", c_gnt, 0);
    check("rst_q_gnt", q_gnt, 0);
    check("rst_mem_wen", mem_wen, 0);
    tick();
    reset = 0; preload = 0; c_req = 0; c_wen = 0; c_wdata = 0; q_req = 0;
    #1;
    check("post_rst_rvalid", {c_rvalid, q_rvalid, s_rvalid}, 0);
    check("post_rst_starve", {starve_q, starve_s}, 0);
    check("idle_mem_wen", mem_wen, 0);

    // Single Q read
    tick();
    q_req = 1; q_addr = 16'h0040; q_wen = 0;
    #1;
    check("q1_gnt", q_gnt, 1);
    check("q1_mem_addr", mem_addr, 16'h0040);
    tick(); q_req = 0; #1;
    check("q1_rvalid_early", q_rvalid, 0);
    tick();
    check("q1_rvalid", q_rvalid, 1);
    check("q1_other_rvalid", {c_rvalid, s_rvalid}, 0);
    check("q1_rdata", rdata, 64'hCAFE_0040_1234_0040);

    // Priority: all three read in the same cycle
    tick();
    c_req = 1; c_addr = 16'h0001; q_req = 1; q_addr = 16'h0002; s_req = 1; s_addr = 16'h0003;
    #1;
    check("pri0_gnts", {c_gnt, q_gnt, s_gnt}, 3'b100);
    tick(); c_req = 0; #1;
    check("pri1_gnts", {c_gnt, q_gnt, s_gnt}, 3'b010);
    tick(); q_req = 0; #1;
    check("pri2_gnts", {c_gnt, q_gnt, s_gnt}, 3'b001);
    check("pri2_rvalid", {c_rvalid, q_rvalid, s_rvalid}, 3'b100);
    check("pri2_rdata", rdata, 64'hCAFE_0001_1234_0001);
    tick(); s_req = 0; #1;
    check("pri3_rvalid", {c_rvalid, q_rvalid, s_rvalid}, 3'b010);
    check("pri3_rdata", rdata, 64'hCAFE_0002_1234_0002);
    tick();
    check("pri4_rvalid", {c_rvalid, q_rvalid, s_rvalid}, 3'b001);
    check("pri4_rdata", rdata, 64'hCAFE_0003_1234_0003);

    // Starvation of Q behind a continuous C stream
    tick();
    c_req = 1; c_addr = 16'h0005; q_req = 1; q_addr = 16'h0006;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("stq_deny%0d", i), {c_gnt, q_gnt, starve_q}, 3'b100);
      tick();
    end
    #1;
    check("stq_force", {c_gnt, q_gnt, starve_q}, 3'b011);
    check("stq_mem_addr", mem_addr, 16'h0006);
    tick(); q_req = 0; #1;
    check("stq_resume", {c_gnt, q_gnt, starve_q}, 3'b100);
    tick(); c_req = 0;
    tick(); tick(); tick();

    // Q write followed by S read of the same word
    q_req = 1; q_addr = 16'h0010; q_wen = 2'b11; q_wdata = 16'hBEEF;
    #1;
    check("wr_gnt", q_gnt, 1);
    check("wr_mem_wen", mem_wen, 2'b11);
    check("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick(); q_req = 0; q_wen = 0; q_wdata = 0; s_req = 1; s_addr = 16'h0010;
    #1;
    check("rd_s_gnt", s_gnt, 1);
    check("rd_mem_wen", mem_wen, 0);
    tick(); s_req = 0; #1;
    check("wr_no_rvalid", {q_rvalid, s_rvalid}, 0);
    tick();
    check("wr_no_q_rvalid", q_rvalid, 0);
    check("rd_s_rvalid", s_rvalid, 1);
    check("rd_rdata", rdata[15:0], 16'hBEEF);

    // Reset while an S read is in flight
    tick();
    s_req = 1; s_addr = 16'h0020;
    #1;
    check("rr_s_gnt", s_gnt, 1);
    tick(); s_req = 0; reset = 1; c_req = 1; c_addr = 16'h0021; #1;
    check("rr_gnts_in_reset", {c_gnt, q_gnt, s_gnt}, 0);
    check("rr_wen_in_reset", mem_wen, 0);
    tick(); reset = 0; c_req = 0; #1;
    check("rr_rvalid_a", {c_rvalid, q_rvalid, s_rvalid}, 0);
    check("rr_starve", {starve_q, starve_s}, 0);
    tick();
    check("rr_rvalid_b", {c_rvalid, q_rvalid, s_rvalid}, 0);
    tick();
    check("rr_rvalid_c", {c_rvalid, q_rvalid, s_rvalid}, 0);

    // Dual saturation: Q forced first, S the cycle after
    c_req = 1; c_addr = 16'h0030; q_req = 1; q_addr = 16'h0031; s_req = 1; s_addr = 16'h0032;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("dual_deny%0d", i), {c_gnt, q_gnt, s_gnt}, 3'b100);
      tick();
    end
    #1;
    check("dual_q_force", {c_gnt, q_gnt, s_gnt, starve_q, starve_s}, 5'b01010);
    check_onehot("dual_onehot_q");
    tick(); q_req = 0; #1;
    check("dual_s_force", {c_gnt, q_gnt, s_gnt, starve_q, starve_s}, 5'b00101);
    check("dual_s_addr", mem_addr, 16'h0032);
    check_onehot("dual_onehot_s");
    tick(); s_req = 0; #1;
    check("dual_c_resume", {c_gnt, q_gnt, s_gnt, starve_q, starve_s}, 5'b10000);
    tick(); c_req = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
